// File: rtl/sweep_pkg.sv
// Shared types and default widths for the sweep controller.
// SWEEP_DWELL_EN adds the endpoint dwell states to the state encoding.
package sweep_pkg;

    localparam int unsigned SWEEP_N = 4;
    localparam int unsigned SWEEP_C = 8;
    localparam int unsigned SWEEP_D = 4;

`ifdef SWEEP_DWELL_EN
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_UP       = 3'd1,
        S_DOWN     = 3'd2,
        S_DWELL_HI = 3'd3,
        S_DWELL_LO = 3'd4
    } sweep_state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } sweep_state_t;
`endif

endpackage

// File: rtl/sweep_dwell_tmr.sv
// Endpoint dwell timer: loads a hold length, counts down to zero, and flags
// the last cycle of the hold. Only instantiated when SWEEP_DWELL_EN is defined.
module sweep_dwell_tmr #(
    parameter int unsigned D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [D-1:0] load_val,
    output logic         expire
);

    logic [D-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A hold of length L spends L cycles in the dwell state: leave when cnt reaches 1.
    assign expire = (cnt == D'(1));

endmodule

// File: rtl/sweep_ctrl.sv
// Triangle sweep controller: counts lo..hi..lo for num_sweeps runs (0 = forever).
// Define SWEEP_DWELL_EN to add the dwell port and endpoint hold states.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int unsigned N = SWEEP_N,
    parameter int unsigned C = SWEEP_C,
    parameter int unsigned D = SWEEP_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] lo,
    input  logic [N-1:0] hi,
    input  logic [C-1:0] num_sweeps,
`ifdef SWEEP_DWELL_EN
    input  logic [D-1:0] dwell,
`endif
    output logic [N-1:0] dout,
    output logic         up,
    output logic         busy,
    output logic         done,
    output logic         err
);

    sweep_state_t state;
    logic [N-1:0] dout_q;
    logic [N-1:0] lo_q;
    logic [N-1:0] hi_q;
    logic [C-1:0] num_q;
    logic [C-1:0] cnt_q;
    logic [C-1:0] cnt_inc;
    logic         last_sweep;

    assign cnt_inc    = cnt_q + 1'b1;
    assign last_sweep = (num_q != '0) && (cnt_inc == num_q);

`ifdef SWEEP_DWELL_EN
    logic [D-1:0] dwell_q;
    logic         tmr_load;
    logic         tmr_expire;

    // Loading on every turnaround is harmless: the count is only consulted in dwell states.
    always_comb begin
        tmr_load = 1'b0;
        if (state == S_UP && dout_q == hi_q) begin
            tmr_load = 1'b1;
        end else if (state == S_DOWN && dout_q == lo_q && !last_sweep) begin
            tmr_load = 1'b1;
        end
    end

    sweep_dwell_tmr #(.D(D)) u_dwell_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (dwell_q),
        .expire   (tmr_expire)
    );
`else
    if (D == 0) begin : g_bad_d
        $error("sweep_ctrl: D must be nonzero");
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            dout_q <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            num_q  <= '0;
            cnt_q  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
`ifdef SWEEP_DWELL_EN
            dwell_q <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == S_IDLE) begin
                if (start && !abort) begin
                    if (lo < hi) begin
                        lo_q   <= lo;
                        hi_q   <= hi;
                        num_q  <= num_sweeps;
                        dout_q <= lo;
                        cnt_q  <= '0;
                        state  <= S_UP;
`ifdef SWEEP_DWELL_EN
                        dwell_q <= dwell;
`endif
                    end else begin
                        err <= 1'b1;
                    end
                end
            end else if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_UP: begin
                        if (dout_q != hi_q) begin
                            dout_q <= dout_q + 1'b1;
                        end else begin
`ifdef SWEEP_DWELL_EN
                            state <= (dwell_q != '0) ? S_DWELL_HI : S_DOWN;
`else
                            state <= S_DOWN;
`endif
                        end
                    end
                    S_DOWN: begin
                        if (dout_q != lo_q) begin
                            dout_q <= dout_q - 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
                            if (last_sweep) begin
                                state <= S_IDLE;
                                done  <= 1'b1;
                            end else begin
`ifdef SWEEP_DWELL_EN
                                state <= (dwell_q != '0) ? S_DWELL_LO : S_UP;
`else
                                state <= S_UP;
`endif
                            end
                        end
                    end
`ifdef SWEEP_DWELL_EN
                    S_DWELL_HI: if (tmr_expire) state <= S_DOWN;
                    S_DWELL_LO: if (tmr_expire) state <= S_UP;
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign dout = dout_q;
    assign up   = (state == S_UP);
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: a cycle-accurate reference model feeds a
// scoreboard compared every cycle, plus directed sequence checks.
`timescale 1ns/1ps
module tb_sweep_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned C = 8;
    localparam int unsigned D = 4;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DHI  = 3;
    localparam int M_DLO  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic [C-1:0] num_sweeps;
`ifdef SWEEP_DWELL_EN
    logic [D-1:0] dwell;
`endif
    logic [N-1:0] dout;
    logic         up;
    logic         busy;
    logic         done;
    logic         err;

    sweep_ctrl #(.N(N), .C(C), .D(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .lo         (lo),
        .hi         (hi),
        .num_sweeps (num_sweeps),
`ifdef SWEEP_DWELL_EN
        .dwell      (dwell),
`endif
        .dout       (dout),
        .up         (up),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dout;
        int up;
        int busy;
        int done;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   cap_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int m_state = M_IDLE;
    int m_dout = 0, m_lo = 0, m_hi = 0, m_n = 0, m_cnt = 0, m_dw = 0, m_tmr = 0;
    int m_done = 0, m_err = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    // Reference model: advances once per rising edge from the inputs held at that edge.
    task automatic model_step();
        m_done = 0;
        m_err  = 0;
        if (rst) begin
            m_state = M_IDLE;
            m_dout = 0; m_lo = 0; m_hi = 0; m_n = 0; m_cnt = 0; m_dw = 0; m_tmr = 0;
        end else if (m_state == M_IDLE) begin
            if (start && !abort) begin
                if (int'(lo) < int'(hi)) begin
                    m_lo = int'(lo);
                    m_hi = int'(hi);
                    m_n  = int'(num_sweeps);
`ifdef SWEEP_DWELL_EN
                    m_dw = int'(dwell);
`else
                    m_dw = 0;
`endif
                    m_dout  = m_lo;
                    m_cnt   = 0;
                    m_state = M_UP;
                end else begin
                    m_err = 1;
                end
            end
        end else if (abort) begin
            m_state = M_IDLE;
        end else begin
            case (m_state)
                M_UP: begin
                    if (m_dout < m_hi) m_dout++;
                    else if (m_dw != 0) begin m_state = M_DHI; m_tmr = m_dw; end
                    else m_state = M_DOWN;
                end
                M_DOWN: begin
                    if (m_dout > m_lo) m_dout--;
                    else begin
                        m_cnt = (m_cnt + 1) % 256;
                        if (m_n != 0 && m_cnt == m_n) begin m_state = M_IDLE; m_done = 1; end
                        else if (m_dw != 0) begin m_state = M_DLO; m_tmr = m_dw; end
                        else m_state = M_UP;
                    end
                end
                M_DHI: begin m_tmr--; if (m_tmr == 0) m_state = M_DOWN; end
                M_DLO: begin m_tmr--; if (m_tmr == 0) m_state = M_UP; end
                default: m_state = M_IDLE;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            exp_q.push_back('{dout: m_dout, up: int'(m_state == M_UP),
                              busy: int'(m_state != M_IDLE), done: m_done, err: m_err});
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cyc_dout", dout, e.dout);
                check("cyc_up",   up,   e.up);
                check("cyc_busy", busy, e.busy);
                check("cyc_done", done, e.done);
                check("cyc_err",  err,  e.err);
                if (n_errors != 0) finish_sim();
            end
        end
    end

    initial begin
        #200000;
        check("watchdog", 0, 1);
        finish_sim();
    end

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic pulse_start(input int l, input int h, input int n);
        lo = N'(l);
        hi = N'(h);
        num_sweeps = C'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records dout on busy cycles until done; poke_at >= 0 pulses start mid-run.
    task automatic run_capture(input int max_cycles, input int poke_at, output bit saw_done);
        saw_done = 1'b0;
        cap_q.delete();
        for (int i = 0; i < max_cycles; i++) begin
            if (busy) cap_q.push_back(int'(dout));
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            start = (i == poke_at);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    function automatic int tri_val(input int k);
        int p;
        p = k % 32;
        return (p < 16) ? p : 31 - p;
    endfunction

    initial begin
        bit got;
        int exp_a[8] = '{2, 3, 4, 5, 5, 4, 3, 2};
        int l, h, n;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        lo = '0; hi = '0; num_sweeps = '0;
`ifdef SWEEP_DWELL_EN
        dwell = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single sweep 2..5..2
        pulse_start(2, 5, 1);
        run_capture(30, -1, got);
        check("a_done_seen", got, 1);
        check("a_len", cap_q.size(), 8);
        for (int i = 0; i < 8 && i < cap_q.size(); i++) check("a_seq", cap_q[i], exp_a[i]);
        check("a_busy_at_done", busy, 0);
        check("a_dout_at_done", dout, 2);
        @(negedge clk);

        // Rejected start: lo == hi
        lo = 4'd5; hi = 4'd5; num_sweeps = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b_err", err, 1);
        check("b_busy", busy, 0);
        check("b_dout", dout, 2);
        @(negedge clk);
        check("b_err_one_cycle", err, 0);

        // lo > hi also rejected; start with abort ignored entirely
        lo = 4'd9; hi = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2_err", err, 1);
        lo = 4'd1; hi = 4'd4; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("c_busy", busy, 0);
        check("c_err", err, 0);
        @(negedge clk);

        // Continuous full-range run, abort after 100 cycles
        pulse_start(0, 15, 0);
        for (int k = 0; k < 100; k++) begin
            check("d_tri", dout, tri_val(k));
            if (k == 40) begin
                lo = 4'd3; hi = 4'd7; start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("d_frozen", dout, tri_val(100));
            check("d_idle", busy, 0);
            check("d_no_done", done, 0);
            @(negedge clk);
        end

        // Reset mid-run, then restart
        pulse_start(1, 3, 3);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("e_dout", dout, 0);
        check("e_up", up, 0);
        check("e_busy", busy, 0);
        check("e_done", done, 0);
        check("e_err", err, 0);
        @(negedge clk);
        pulse_start(1, 3, 1);
        run_capture(30, -1, got);
        check("e_restart_done", got, 1);
        check("e_restart_len", cap_q.size(), 6);
        @(negedge clk);

        // Random bounded runs: length must be n*2*(hi-lo+1)
        for (int r = 0; r < 6; r++) begin
            l = int'($urandom_range(0, 13));
            h = int'($urandom_range(l + 1, 15));
            n = int'($urandom_range(1, 2));
            pulse_start(l, h, n);
            run_capture(200, -1, got);
            check("r_done_seen", got, 1);
            check("r_len", cap_q.size(), n * 2 * (h - l + 1));
            @(negedge clk);
        end

`ifdef SWEEP_DWELL_EN
        begin
            int exp_f[21] = '{0, 1, 2, 2, 2, 2, 2, 1, 0, 0, 0, 0, 0, 1, 2, 2, 2, 2, 2, 1, 0};
            dwell = 4'd3;
            pulse_start(0, 2, 2);
            run_capture(60, 7, got);
            check("f_done_seen", got, 1);
            check("f_len", cap_q.size(), 21);
            for (int i = 0; i < 21 && i < cap_q.size(); i++) check("f_seq", cap_q[i], exp_f[i]);
            check("f_dout_at_done", dout, 0);
            dwell = 4'd0;
            @(negedge clk);
        end
`endif

        repeat (2) @(negedge clk);
        finish_sim();
    end

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameters SHALL be: N, 4, count width; C, 8, sweep-count width; D, 4, dwell width.
REQ-002 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 start  in  1  begin a sweep run; sampled only in IDLE.
REQ-005 abort  in  1  terminate a run; takes effect on the next edge.
REQ-006 lo  in  N  lower limit; latched at accepted start.
REQ-007 hi  in  N  upper limit; latched at accepted start.
REQ-008 num_sweeps  in  C  sweeps to run (0 = continuous); latched at accepted start.
REQ-009 dwell  in  D  endpoint hold cycles; port present only with SWEEP_DWELL_EN.
REQ-010 dout  out  N  current count value.
REQ-011 up  out  1  direction; 1 in UP, 0 in all other states.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 done  out  1  one-cycle pulse on normal run completion.
REQ-014 err  out  1  one-cycle pulse on a rejected start.

Function
REQ-015 FSM states SHALL be IDLE, UP and DOWN, plus DWELL_HI and DWELL_LO with SWEEP_DWELL_EN.
REQ-016 IDLE: start=1, abort=0 and lo<hi -> latch lo/hi/num_sweeps/dwell, dout<=lo, sweep counter<=0, next UP.
REQ-017 IDLE: start=1 with lo>=hi -> err=1 next cycle, remain IDLE, dout unchanged.
REQ-018 UP: dout<hi -> dout<=dout+1; dout==hi -> dout held, next DOWN (or DWELL_HI).
REQ-019 DOWN: dout>lo -> dout<=dout-1; dout==lo -> dout held, sweep counter+1, one sweep ends.
REQ-020 End of sweep: counter+1 == num_sweeps (num_sweeps!=0) -> IDLE with done=1 for that one cycle; else next UP (or DWELL_LO).
REQ-021 One sweep without dwell SHALL last exactly 2*(hi-lo+1) cycles, and each endpoint value SHALL appear on two consecutive cycles.
REQ-022 num_sweeps=0: sweep counter SHALL wrap modulo 2^C and the run SHALL continue until abort or rst.
REQ-023 abort in any non-IDLE state -> IDLE next edge, dout frozen at its current value, done=0; abort SHALL outrank every other transition.
REQ-024 start while busy SHALL be ignored; start and abort together in IDLE SHALL be ignored.
REQ-025 dout arithmetic SHALL be N-bit unsigned and SHALL never leave [lo,hi] during a run; lo=0 and hi=2^N-1 SHALL work without wrap.

Reset
REQ-026 rst=1 SHALL force IDLE, dout=0, up=0, busy=0, done=0, err=0, sweep counter=0, latched limits=0 on the next edge.
REQ-027 rst asserted mid-run SHALL abandon the run with no done or err pulse.

Configuration
REQ-028 With SWEEP_DWELL_EN defined, latched dwell!=0 SHALL hold dout for dwell cycles in DWELL_HI after the hi turnaround cycle, and in DWELL_LO after each non-final lo turnaround cycle, with up=0; dwell=0 SHALL skip the dwell states.
REQ-029 Without SWEEP_DWELL_EN, the dwell port, both dwell states and the timer SHALL be absent, and timing SHALL match REQ-021.

Structure
REQ-030 Package sweep_pkg SHALL hold the sweep_state_t enum and the default N/C/D constants.
REQ-031 Sub-module sweep_dwell_tmr (load, D-bit down-count, expire flag) SHALL be instantiated only under SWEEP_DWELL_EN.

Verification
REQ-032 lo=2, hi=5, num_sweeps=1, start -> dout 2,3,4,5,5,4,3,2 then done=1 with IDLE, busy 1->0.
REQ-033 lo=5, hi=5, start -> err=1 for one cycle, busy stays 0, dout unchanged.
REQ-034 lo=0, hi=15, num_sweeps=0, abort after 100 cycles -> dout frozen, no done, and dout never wraps past 0 or 15.
REQ-035 num_sweeps=3, lo=1, hi=3, rst at cycle 10 -> all outputs reset next edge, no done; start re-accepted afterward.
REQ-036 SWEEP_DWELL_EN, dwell=3, lo=0, hi=2, num_sweeps=2 -> dout 0,1,2,2,2,2,2,1,0,0,0,0,0,1,2,2,2,2,2,1,0 with done=1 on the final dout=0 cycle; start pulsed while busy is ignored.
REQ-037 Bench SHALL keep a cycle-accurate reference model, compare dout/up/busy/done/err every cycle, and stop with a fail message on the first mismatch.
